// File: rtl/snake_pkg.sv
// Shared types and cell arithmetic for the snake game-logic stage.
// Cells are {row[3:0], col[3:0]} on a 16x16 torus.
package snake_pkg;

  localparam int GRID_DIM = 16;
  localparam int MAX_LEN  = 256;

  typedef logic [7:0] cell_t;
  typedef logic [MAX_LEN-1:0][7:0] body_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  // Each nibble wraps independently, so the playfield has no walls.
  function automatic cell_t next_cell(cell_t c, dir_t d);
    logic [3:0] row;
    logic [3:0] col;
    row = c[7:4];
    col = c[3:0];
    case (d)
      UP:    row = row - 4'd1;
      DOWN:  row = row + 4'd1;
      LEFT:  col = col - 4'd1;
      RIGHT: col = col + 4'd1;
    endcase
    return {row, col};
  endfunction

  // Opposite directions differ by exactly two in the encoding.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (2'(a) ^ 2'(b)) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control and body-state bundle between the game controller and snake_body.
// The slave side is the snake_body block itself.
interface snake_body_if;
  import snake_pkg::*;

  logic        restart;
  logic        step;
  dir_t        dir;
  logic        grow;
  body_t       pos;
  logic [7:0]  length;
  cell_t       head;
  logic        busy;
  logic        dead;

  modport master (
    output restart, step, dir, grow,
    input  pos, length, head, busy, dead
  );

  modport slave (
    input  restart, step, dir, grow,
    output pos, length, head, busy, dead
  );

endinterface

// File: rtl/snake_body.sv
// Snake body register: advances one cell per game tick, grows on request and
// detects self-collision by scanning the body one entry per cycle.
module snake_body
  import snake_pkg::*;
#(
  parameter cell_t START_POS = 8'h88,
  parameter int    START_LEN = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  snake_body_if.slave  bus
);

  state_t     state;
  dir_t       heading;
  cell_t      nh;
  logic       grow_q;
  logic       hit;
  logic       dead;
  logic       busy;
  logic [7:0] idx;
  logic [7:0] limit;
  body_t      pos;
  logic [7:0] length;

  dir_t       next_heading;
  logic       accept;
  logic       grow_ok;
  logic [7:0] next_limit;
  logic       commit;

  function automatic body_t init_body();
    body_t b;
    b = '0;
    for (int i = 0; i < START_LEN; i++) b[i] = START_POS - cell_t'(i);
    return b;
  endfunction

  assign next_heading = is_opposite(bus.dir, heading) ? heading : bus.dir;
  assign accept       = (state == IDLE) && !busy && bus.step && !dead;
  assign grow_ok      = bus.grow && (length != 8'hFF);
  // The tail vacates this tick unless growing, so it is left out of the scan.
  assign next_limit   = grow_ok ? length : length - 8'd1;
  assign commit       = (state == COMMIT) && !hit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values of state, idx and pos.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      heading <= RIGHT;
      nh      <= START_POS;
      grow_q  <= 1'b0;
      hit     <= 1'b0;
      dead    <= 1'b0;
      busy    <= 1'b0;
      idx     <= 8'd0;
      limit   <= 8'd0;
    end else if (bus.restart) begin
      state   <= IDLE;
      heading <= RIGHT;
      nh      <= START_POS;
      grow_q  <= 1'b0;
      hit     <= 1'b0;
      dead    <= 1'b0;
      busy    <= 1'b0;
      idx     <= 8'd0;
      limit   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (accept) begin
            heading <= next_heading;
            nh      <= next_cell(pos[0], next_heading);
            grow_q  <= grow_ok;
            hit     <= 1'b0;
            idx     <= 8'd0;
            limit   <= next_limit;
            busy    <= 1'b1;
            state   <= (next_limit == 8'd0) ? COMMIT : SCAN;
          end
        end
        SCAN: begin
          if (pos[idx] == nh) hit <= 1'b1;
          idx <= idx + 8'd1;
          if (idx == limit - 8'd1) state <= COMMIT;
        end
        COMMIT: begin
          // busy is held through the return to IDLE and cleared one cycle later.
          if (hit) dead <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the body array is explicitly reset because the grid stage reads all
  // 256 entries, including those beyond length, straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos    <= init_body();
      length <= 8'(START_LEN);
    end else if (bus.restart) begin
      pos    <= init_body();
      length <= 8'(START_LEN);
    end else if (commit) begin
      pos    <= {pos[MAX_LEN-2:0], nh};
      length <= length + {7'd0, grow_q};
    end
  end

  assign bus.pos    = pos;
  assign bus.length = length;
  assign bus.head   = pos[0];
  assign bus.busy   = busy;
  assign bus.dead   = dead;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset state, moves, wrap, reversal, growth
// saturation, self-collision, tail chase, busy handling and async reset.
module tb_snake_body;
  import snake_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt;

  snake_body_if bus ();

  snake_body dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic move(input dir_t d, input logic g);
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir  = d;
    bus.grow = g;
    @(negedge clk);
    bus.step = 1'b0;
    bus.grow = 1'b0;
    for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
    if (bus.busy) check("move_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic move_n(input dir_t d, input int n, input logic g);
    for (int i = 0; i < n; i++) move(d, g);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.restart = 1'b0;
    bus.step    = 1'b0;
    bus.dir     = RIGHT;
    bus.grow    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_head",   32'(bus.head),   32'h88);
    check("rst_pos1",   32'(bus.pos[1]), 32'h87);
    check("rst_pos2",   32'(bus.pos[2]), 32'h86);
    check("rst_pos3",   32'(bus.pos[3]), 32'h00);
    check("rst_length", 32'(bus.length), 32'd3);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_dead",   32'(bus.dead),   32'd0);

    // Single move RIGHT: busy 4 cycles, pos appears after limit+2 = 4 edges
    bus.step = 1'b1;
    bus.dir  = RIGHT;
    @(negedge clk);
    bus.step = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy) busy_cnt++;
      if (i == 2) check("t1_head_during_scan", 32'(bus.head), 32'h88);
      if (i == 3) check("t1_head_after_commit", 32'(bus.head), 32'h89);
      @(negedge clk);
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd4);
    check("t1_pos0",   32'(bus.pos[0]), 32'h89);
    check("t1_pos1",   32'(bus.pos[1]), 32'h88);
    check("t1_pos2",   32'(bus.pos[2]), 32'h87);
    check("t1_length", 32'(bus.length), 32'd3);
    check("t1_dead",   32'(bus.dead),   32'd0);

    // Step while busy is ignored
    do_restart();
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir  = DOWN;
    @(negedge clk);
    bus.dir  = RIGHT;
    repeat (3) @(negedge clk);
    bus.step = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_busy_step_head", 32'(bus.head), 32'h98);
    check("t6_busy_step_pos1", 32'(bus.pos[1]), 32'h88);

    // Async reset mid-SCAN aborts the move
    do_restart();
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir  = DOWN;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_arst_busy", 32'(bus.busy),   32'd0);
    check("t6_arst_head", 32'(bus.head),   32'h88);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_arst_head_later", 32'(bus.head),   32'h88);
    check("t6_arst_pos1",       32'(bus.pos[1]), 32'h87);
    check("t6_arst_length",     32'(bus.length), 32'd3);
    check("t6_arst_busy_later", 32'(bus.busy),   32'd0);

    // Column wrap then row wrap
    do_restart();
    move_n(RIGHT, 7, 1'b0);
    check("t2_head_8f", 32'(bus.head), 32'h8F);
    move(RIGHT, 1'b0);
    check("t2_col_wrap", 32'(bus.head), 32'h80);
    do_restart();
    move_n(UP, 8, 1'b0);
    check("t2_head_08", 32'(bus.head), 32'h08);
    move(UP, 1'b0);
    check("t2_row_wrap", 32'(bus.head), 32'hF8);

    // Reversal ignored
    do_restart();
    move(LEFT, 1'b0);
    check("t3_rev_head", 32'(bus.head), 32'h89);
    check("t3_rev_dead", 32'(bus.dead), 32'd0);

    // Two growing moves
    do_restart();
    move_n(RIGHT, 2, 1'b1);
    check("t4_length", 32'(bus.length), 32'd5);
    check("t4_pos0", 32'(bus.pos[0]), 32'h8A);
    check("t4_pos1", 32'(bus.pos[1]), 32'h89);
    check("t4_pos2", 32'(bus.pos[2]), 32'h88);
    check("t4_pos3", 32'(bus.pos[3]), 32'h87);
    check("t4_pos4", 32'(bus.pos[4]), 32'h86);

    // Grow along a serpentine covering all 256 cells; length saturates at 255
    do_restart();
    move_n(RIGHT, 7, 1'b1);
    for (int r = 0; r < 7; r++) begin
      move(DOWN, 1'b1);
      move_n((r % 2 == 0) ? LEFT : RIGHT, 15, 1'b1);
    end
    for (int r = 0; r < 8; r++) begin
      move(DOWN, 1'b1);
      move_n((r % 2 == 0) ? RIGHT : LEFT, 15, 1'b1);
    end
    move(DOWN, 1'b1);
    move_n(RIGHT, 4, 1'b1);
    check("t4_len_255",     32'(bus.length), 32'd255);
    check("t4_head_84",     32'(bus.head),   32'h84);
    move(RIGHT, 1'b1);
    check("t4_len_sat",     32'(bus.length), 32'd255);
    check("t4_sat_head",    32'(bus.head),   32'h85);
    check("t4_sat_pos1",    32'(bus.pos[1]), 32'h84);
    check("t4_sat_dead",    32'(bus.dead),   32'd0);

    // Self-collision at length 5
    do_restart();
    move_n(RIGHT, 2, 1'b1);
    move(UP, 1'b0);
    move(LEFT, 1'b0);
    check("t5_pre_dead", 32'(bus.dead), 32'd0);
    move(DOWN, 1'b0);
    check("t5_dead",        32'(bus.dead),   32'd1);
    check("t5_frozen_head", 32'(bus.head),   32'h79);
    check("t5_frozen_pos4", 32'(bus.pos[4]), 32'h88);
    check("t5_frozen_len",  32'(bus.length), 32'd5);
    move(LEFT, 1'b0);
    check("t5_ignored_head", 32'(bus.head), 32'h79);
    check("t5_ignored_busy", 32'(bus.busy), 32'd0);
    do_restart();
    @(negedge clk);
    check("t5_restart_head", 32'(bus.head),   32'h88);
    check("t5_restart_len",  32'(bus.length), 32'd3);
    check("t5_restart_dead", 32'(bus.dead),   32'd0);
    check("t5_restart_pos4", 32'(bus.pos[4]), 32'h00);

    // Tail chase: entering the vacating tail is safe, unless growing
    move(RIGHT, 1'b1);
    move(DOWN, 1'b0);
    move(LEFT, 1'b0);
    move(UP, 1'b0);
    check("t5_chase_head", 32'(bus.head),   32'h88);
    check("t5_chase_pos3", 32'(bus.pos[3]), 32'h89);
    check("t5_chase_dead", 32'(bus.dead),   32'd0);
    move(RIGHT, 1'b1);
    check("t5_grow_tail_dead", 32'(bus.dead),   32'd1);
    check("t5_grow_tail_len",  32'(bus.length), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
